uart_tx_arb: RTL
================

# uart_tx_arb

Arbitrates two byte-stream sources (s0: ADC sample frames, s1: status/housekeeping frames) onto the single UART transmitter running in the clk_u domain. It works at frame granularity with round-robin fairness and a stall watchdog. It issues no traffic until system initialization reports complete, so the UART baud word is latched before the first byte leaves.

## Interface
Parameters:
- TIMEOUT_LEN, 16'd1000, number of consecutive stalled clk_u cycles that aborts a granted frame

Ports:
- clk_u  in  1  UART-domain clock
- rst  in  1  reset; asynchronous, active-low
- enable  in  1  initialization complete; arbitration starts only when high (synchronous to clk_u)
- s0_valid  in  1  source 0 byte available
- s0_data  in  8  source 0 byte
- s0_last  in  1  byte is last of frame
- s0_ready  out  1  source 0 byte accepted this cycle
- s1_valid, s1_data[7:0], s1_last, s1_ready  same as s0, for source 1
- tx_data  out  8  byte to UART, held stable until next tx_start
- tx_start  out  1  one-cycle launch pulse to UART
- tx_busy  in  1  UART busy; rises no earlier than the cycle after tx_start, falls when the stop bit is done
- grant  out  2  one-hot owner of the UART (bit0 = s0); 2'b00 when idle
- timeout_err  out  1  one-cycle pulse on watchdog abort

## Operation
- States: IDLE, XFER, WAIT_BUSY, WAIT_DONE.
- IDLE: grant=00. If enable && (s0_valid || s1_valid), choose the winner and go to XFER with grant set on that edge.
  - Single request wins directly.
  - Both requesting: the source not equal to ptr wins.
  - ptr = index of the last source granted. Reset value is 1, so s0 wins the first tie.
- XFER: sX_ready = (state==XFER) && grant[X] && sX_valid && !tx_busy. This is combinational; the non-granted ready is always 0.
  - On accept: tx_data<=sX_data, last_r<=sX_last, tx_start<=1 for one cycle, go to WAIT_BUSY.
- WAIT_BUSY: stay until tx_busy==1, then go to WAIT_DONE.
- WAIT_DONE: stay until tx_busy==0.
  - If last_r: go to IDLE, ptr<=granted index, grant<=00.
  - Else: return to XFER.
- enable is sampled only in IDLE. Deassertion mid-frame lets the frame finish.
- Watchdog: 16-bit counter.
  - Cleared in IDLE and on every accept.
  - Increments each cycle in XFER without accept, and each cycle in WAIT_BUSY or WAIT_DONE.
  - When it equals TIMEOUT_LEN:
    - timeout_err pulses one cycle.
    - state goes to IDLE, grant goes to 00.
    - ptr becomes the aborted source, so the other source wins the next tie.
    - counter clears.
- An aborted source's remaining bytes are not consumed by the block. The next grant restarts from whatever that source presents.
- The ready signals never assert outside XFER. No byte is ever accepted without a matching tx_start.

## Timing
- Reset (async, rst low): state IDLE, grant=00, tx_start=0, tx_data=8'h00, timeout_err=0, s0_ready=s1_ready=0, ptr=1, counter=0, last_r=0.
- Request to grant: 1 cycle. Valid sampled in IDLE at edge n gives grant valid after edge n.
- First accept: the first cycle in XFER with valid && !tx_busy. tx_start is high in the following cycle with tx_data already valid.
- Per-byte overhead: 1 accept cycle + 1 WAIT_BUSY cycle (minimum) + UART busy time + 1 cycle to return to XFER.
- Frame end to next grant: WAIT_DONE→IDLE (1 edge), IDLE→XFER (1 edge).
- tx_start is never asserted while tx_busy==1.
- timeout_err asserts on the edge at which TIMEOUT_LEN stalled cycles have elapsed. It cannot coincide with tx_start.
- Reset mid-frame: immediate return to reset values. An in-flight UART byte completes on its own; the block ignores tx_busy until it returns to XFER.

## Test plan
- enable=0, s0_valid=1 for 100 cycles -> grant=00, no tx_start. Then enable=1 -> grant=01 one cycle later and tx_start with s0 data one cycle after accept.
- s0 frame 0x55,0xAA,0x0F(last); UART model busy 10 cycles per byte -> exactly three tx_start pulses with those tx_data values, grant=01 throughout, then grant=00.
- s0 and s1 both valid from reset, 2-byte frames repeatedly -> order s0,s1,s0,s1. No byte of one frame is interleaved into another.
- s1 granted, s1_valid drops after first byte for TIMEOUT_LEN cycles with s0_valid=1 -> one timeout_err pulse, grant 10→00→01, and the s0 frame transmits intact.
- UART model never raises tx_busy after tx_start -> timeout_err after TIMEOUT_LEN cycles in WAIT_BUSY, grant=00.
- rst low during WAIT_DONE of s0 byte 2 -> all outputs 0 immediately. After release with both sources valid, s0 is granted first (ptr=1).

Source files
------------

// File: rtl/uart_tx_arb.sv
// Frame-level round-robin arbiter feeding one UART transmitter.
//
// Two byte-stream sources (s0: ADC sample frames, s1: housekeeping frames) compete for the
// UART. Once a source is granted it owns the UART until its last byte has been sent. A
// watchdog aborts a frame that stalls for TIMEOUT_LEN cycles. No grant is issued until
// enable (initialization complete) is high.
//
// Ports:
//   clk_u        UART-domain clock
//   rst          asynchronous active-low reset
//   enable       initialization complete; sampled only while idle
//   sX_valid     source X byte available
//   sX_data      source X byte
//   sX_last      byte is the last of its frame
//   sX_ready     source X byte accepted this cycle (combinational)
//   tx_data      byte to the UART, held until the next tx_start
//   tx_start     one-cycle launch pulse to the UART
//   tx_busy      UART busy
//   grant        one-hot owner of the UART (bit0 = s0), 2'b00 when idle
//   timeout_err  one-cycle pulse on watchdog abort
module uart_tx_arb #(
  parameter logic [15:0] TIMEOUT_LEN = 16'd1000
) (
  input  logic       clk_u,
  input  logic       rst,
  input  logic       enable,
  input  logic       s0_valid,
  input  logic [7:0] s0_data,
  input  logic       s0_last,
  output logic       s0_ready,
  input  logic       s1_valid,
  input  logic [7:0] s1_data,
  input  logic       s1_last,
  output logic       s1_ready,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  output logic [1:0] grant,
  output logic       timeout_err
);

  typedef enum logic [1:0] {StIdle, StXfer, StWaitBusy, StWaitDone} state_e;

  state_e      state_q;
  logic [1:0]  grant_q;
  logic        ptr_q;      // index of the source granted most recently
  logic [15:0] cnt_q;      // watchdog: stalled cycles since the last accept
  logic        last_q;
  logic [7:0]  tx_data_q;
  logic        tx_start_q;
  logic        timeout_q;

  logic        accept;
  logic [7:0]  sel_data;
  logic        sel_last;
  logic        wd_hit;
  logic [15:0] cnt_inc;
  logic [1:0]  grant_pick;

  assign s0_ready = (state_q == StXfer) && grant_q[0] && s0_valid && !tx_busy;
  assign s1_ready = (state_q == StXfer) && grant_q[1] && s1_valid && !tx_busy;

  always_comb begin
    accept   = s0_ready | s1_ready;
    sel_data = grant_q[1] ? s1_data : s0_data;
    sel_last = grant_q[1] ? s1_last : s0_last;
    cnt_inc  = cnt_q + 16'd1;
    // Abort on the edge that completes the TIMEOUT_LEN-th stalled cycle.
    wd_hit   = (cnt_q == TIMEOUT_LEN - 16'd1);
    // On a tie the source that was not granted last wins.
    if (s1_valid && (!s0_valid || !ptr_q)) begin
      grant_pick = 2'b10;
    end else begin
      grant_pick = 2'b01;
    end
  end

  always_ff @(posedge clk_u or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      grant_q    <= 2'b00;
      ptr_q      <= 1'b1;
      cnt_q      <= 16'd0;
      last_q     <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      timeout_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          cnt_q <= 16'd0;
          if (enable && (s0_valid || s1_valid)) begin
            grant_q <= grant_pick;
            state_q <= StXfer;
          end
        end
        StXfer: begin
          if (accept) begin
            tx_data_q  <= sel_data;
            last_q     <= sel_last;
            tx_start_q <= 1'b1;
            cnt_q      <= 16'd0;
            state_q    <= StWaitBusy;
          end else if (wd_hit) begin
            timeout_q <= 1'b1;
            ptr_q     <= grant_q[1];
            grant_q   <= 2'b00;
            cnt_q     <= 16'd0;
            state_q   <= StIdle;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        StWaitBusy, StWaitDone: begin
          if (wd_hit) begin
            timeout_q <= 1'b1;
            ptr_q     <= grant_q[1];
            grant_q   <= 2'b00;
            cnt_q     <= 16'd0;
            state_q   <= StIdle;
          end else begin
            cnt_q <= cnt_inc;
            if (state_q == StWaitBusy) begin
              if (tx_busy) begin
                state_q <= StWaitDone;
              end
            end else if (!tx_busy) begin
              if (last_q) begin
                ptr_q   <= grant_q[1];
                grant_q <= 2'b00;
                state_q <= StIdle;
              end else begin
                state_q <= StXfer;
              end
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign tx_data     = tx_data_q;
  assign tx_start    = tx_start_q;
  assign grant       = grant_q;
  assign timeout_err = timeout_q;

endmodule
